// File: rtl/l1d_tlb_if.sv
// Walker response type and the L1D-side request/response interface of l1d_tlb.
// The L1D drives through the master modport and the TLB sits on the slave modport.
package l1d_tlb_pkg;
    typedef struct packed {
        logic [63:0] paddr;
        logic        fault;
        logic        dirty;
        logic        readable;
        logic        writable;
        logic        executable;
        logic        user;
        logic [1:0]  pgsize;
    } page_walk_rsp_t;
endpackage

interface l1d_tlb_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_va;
    logic        req_store;
    logic        rsp_valid;
    logic [63:0] rsp_pa;
    logic        rsp_fault;
    logic        rsp_hit;

    modport master (
        output req_valid, req_va, req_store,
        input  req_ready, rsp_valid, rsp_pa, rsp_fault, rsp_hit
    );

    modport slave (
        input  req_valid, req_va, req_store,
        output req_ready, rsp_valid, rsp_pa, rsp_fault, rsp_hit
    );
endinterface

// File: rtl/l1d_tlb.sv
// Fully associative Sv39 data-side TLB (4K/2M/1G) in front of the page-table walker.
// Optional hit/miss statistics counters are built only when TLB_STATS_EN is defined.
module l1d_tlb
    import l1d_tlb_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_tlb,
    l1d_tlb_if.slave       l1d,
    output logic           walk_req,
    output logic [63:0]    walk_va,
    input  logic           walk_rsp_valid,
    input  page_walk_rsp_t walk_rsp,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
);
    localparam int IDX_W = $clog2(N_ENTRIES);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WALK      = 3'd2;
    localparam logic [2:0] WALK_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    function automatic logic vpn_match(input logic [26:0] vpn, input logic [1:0] pgsize,
                                       input logic [26:0] va_vpn);
        case (pgsize)
            2'd0:    return vpn[26:18] == va_vpn[26:18];
            2'd1:    return vpn[26:9] == va_vpn[26:9];
            default: return vpn == va_vpn;
        endcase
    endfunction

    function automatic logic [63:0] compose_pa(input logic [43:0] ppn, input logic [1:0] pgsize,
                                               input logic [29:0] va_lo);
        case (pgsize)
            2'd0:    return {8'd0, ppn[43:18], va_lo[29:0]};
            2'd1:    return {8'd0, ppn[43:9], va_lo[20:0]};
            default: return {8'd0, ppn, va_lo[11:0]};
        endcase
    endfunction

    function automatic logic perm_fault(input logic store, input logic readable, input logic writable);
        return (store & ~writable) | (~store & ~readable);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [2:0]           state;
    logic [IDX_W-1:0]     repl_ptr;
    logic                 drop_fill;
    logic [63:0]          rsp_pa_q;
    logic                 rsp_fault_q;
    logic                 rsp_hit_q;

    logic [63:0]          va_q;
    logic                 store_q;
    logic                 refill_same;
    logic [IDX_W-1:0]     refill_idx;

    logic [N_ENTRIES-1:0] ent_valid;
    logic [26:0]          ent_vpn    [N_ENTRIES];
    logic [43:0]          ent_ppn    [N_ENTRIES];
    logic [1:0]           ent_pgsize [N_ENTRIES];
    logic [N_ENTRIES-1:0] ent_r;
    logic [N_ENTRIES-1:0] ent_w;
    logic [N_ENTRIES-1:0] ent_d;

    logic                 lkp_match;
    logic [IDX_W-1:0]     lkp_idx;

    always_comb begin
        lkp_match = 1'b0;
        lkp_idx   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (ent_valid[i] && vpn_match(ent_vpn[i], ent_pgsize[i], va_q[38:12])) begin
                lkp_match = 1'b1;
                lkp_idx   = IDX_W'(i);
            end
        end
    end

    logic             canonical;
    logic             dirty_miss;
    logic             tlb_hit;
    logic [63:0]      walk_pa;
    logic             walk_flt;
    logic             fill_en;
    logic [IDX_W-1:0] fill_idx;

    assign canonical  = (&va_q[63:38]) | ~(|va_q[63:38]);
    // A store to a clean writable page must re-walk so the walker can set D.
    assign dirty_miss = store_q & ent_w[lkp_idx] & ~ent_d[lkp_idx];
    assign tlb_hit    = lkp_match & ~dirty_miss;
    assign walk_pa    = compose_pa(walk_rsp.paddr[55:12], walk_rsp.pgsize, va_q[29:0]);
    assign walk_flt   = walk_rsp.fault | perm_fault(store_q, walk_rsp.readable, walk_rsp.writable);
    assign fill_en    = (state == WALK) & walk_rsp_valid & ~walk_rsp.fault & ~drop_fill & ~clear_tlb;
    assign fill_idx   = refill_same ? refill_idx : repl_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            repl_ptr    <= '0;
            drop_fill   <= 1'b0;
            ent_valid   <= '0;
            rsp_pa_q    <= '0;
            rsp_fault_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            walk_req    <= 1'b0;
            walk_va     <= '0;
        end else begin
            walk_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (l1d.req_valid)
                        state <= LOOKUP;
                end
                LOOKUP: begin
                    if (!canonical) begin
                        rsp_pa_q    <= '0;
                        rsp_fault_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        state       <= RESP;
                    end else if (tlb_hit) begin
                        rsp_pa_q    <= compose_pa(ent_ppn[lkp_idx], ent_pgsize[lkp_idx], va_q[29:0]);
                        rsp_fault_q <= perm_fault(store_q, ent_r[lkp_idx], ent_w[lkp_idx]);
                        rsp_hit_q   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        walk_req  <= 1'b1;
                        walk_va   <= va_q;
                        drop_fill <= 1'b0;
                        state     <= WALK;
                    end
                end
                WALK: begin
                    if (clear_tlb)
                        drop_fill <= 1'b1;
                    if (walk_rsp_valid) begin
                        rsp_pa_q    <= walk_rsp.fault ? '0 : walk_pa;
                        rsp_fault_q <= walk_flt;
                        rsp_hit_q   <= 1'b0;
                        state       <= WALK_DONE;
                        if (fill_en && !refill_same)
                            repl_ptr <= repl_ptr + IDX_W'(1);
                    end
                end
                WALK_DONE: state <= RESP;
                RESP:      state <= IDLE;
                default:   state <= IDLE;
            endcase

            // Invalidation wins over a fill landing in the same cycle.
            if (clear_tlb)
                ent_valid <= '0;
            else if (fill_en)
                ent_valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && l1d.req_valid) begin
            va_q    <= l1d.req_va;
            store_q <= l1d.req_store;
        end
        if (state == LOOKUP) begin
            refill_same <= lkp_match;
            refill_idx  <= lkp_idx;
        end
        if (fill_en) begin
            ent_vpn[fill_idx]    <= va_q[38:12];
            ent_ppn[fill_idx]    <= walk_rsp.paddr[55:12];
            ent_pgsize[fill_idx] <= walk_rsp.pgsize;
            ent_r[fill_idx]      <= walk_rsp.readable;
            ent_w[fill_idx]      <= walk_rsp.writable;
            ent_d[fill_idx]      <= walk_rsp.dirty;
        end
    end

    assign l1d.req_ready = (state == IDLE);
    assign l1d.rsp_valid = (state == RESP);
    assign l1d.rsp_pa    = rsp_pa_q;
    assign l1d.rsp_fault = rsp_fault_q;
    assign l1d.rsp_hit   = rsp_hit_q;

`ifdef TLB_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == LOOKUP && canonical && !tlb_hit)
                miss_cnt <= sat_inc(miss_cnt);
            if (state == RESP && rsp_hit_q)
                hit_cnt <= sat_inc(hit_cnt);
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

    logic unused_walk_bits;
    assign unused_walk_bits = ^{walk_rsp.paddr[63:56], walk_rsp.paddr[11:0],
                                walk_rsp.executable, walk_rsp.user};
endmodule

// File: tb/tb_l1d_tlb.sv
// Directed bench for l1d_tlb: a table of translation vectors with a scripted walker,
// followed by hand-written sequences for spurious walker responses, mid-walk reset and eviction.
module tb_l1d_tlb;
    import l1d_tlb_pkg::*;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear_tlb;
    logic           walk_req;
    logic [63:0]    walk_va;
    logic           walk_rsp_valid;
    page_walk_rsp_t walk_rsp;
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;

    l1d_tlb_if l1d ();

    l1d_tlb #(.N_ENTRIES(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .clear_tlb      (clear_tlb),
        .l1d            (l1d),
        .walk_req       (walk_req),
        .walk_va        (walk_va),
        .walk_rsp_valid (walk_rsp_valid),
        .walk_rsp       (walk_rsp),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] va;
        logic        store;
        logic        walk;
        logic [1:0]  clr;   // 0 none, 1 clear while waiting in WALK, 2 clear with walk_rsp_valid
        logic [63:0] paddr;
        logic [1:0]  pg;
        logic        wf;
        logic        r;
        logic        w;
        logic        d;
        logic [63:0] exp_pa;
        logic        exp_fault;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic [63:0] va, input logic store, input logic walk,
                                input logic [1:0] clr, input logic [63:0] paddr, input logic [1:0] pg,
                                input logic wf, input logic r, input logic w, input logic d,
                                input logic [63:0] exp_pa, input logic exp_fault, input logic exp_hit);
        vec_t v;
        v.va = va; v.store = store; v.walk = walk; v.clr = clr; v.paddr = paddr; v.pg = pg;
        v.wf = wf; v.r = r; v.w = w; v.d = d;
        v.exp_pa = exp_pa; v.exp_fault = exp_fault; v.exp_hit = exp_hit;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk1 ({tag, ".req_ready"}, l1d.req_ready, 1'b1);
        chk1 ({tag, ".rsp_valid"}, l1d.rsp_valid, 1'b0);
        chk1 ({tag, ".rsp_fault"}, l1d.rsp_fault, 1'b0);
        chk1 ({tag, ".rsp_hit"},   l1d.rsp_hit,   1'b0);
        chk64({tag, ".rsp_pa"},    l1d.rsp_pa,    64'd0);
        chk1 ({tag, ".walk_req"},  walk_req,      1'b0);
        chk64({tag, ".walk_va"},   walk_va,       64'd0);
        chk64({tag, ".hit_count"}, 64'(hit_count),  64'd0);
        chk64({tag, ".miss_count"}, 64'(miss_count), 64'd0);
    endtask

    // Cycle 0 = accept, cycle 1 = lookup, hit response in cycle 2;
    // on a miss the walker answers in cycle 3 and the response lands in cycle 5.
    task automatic do_req(input string tag, input vec_t v);
        @(negedge clk);
        chk1({tag, ".ready"}, l1d.req_ready, 1'b1);
        l1d.req_valid = 1'b1;
        l1d.req_va    = v.va;
        l1d.req_store = v.store;
        @(negedge clk);
        l1d.req_valid = 1'b0;
        chk1({tag, ".busy"}, l1d.req_ready, 1'b0);
        @(negedge clk);
        if (v.walk) begin
            chk1 ({tag, ".walk_req"}, walk_req, 1'b1);
            chk64({tag, ".walk_va"},  walk_va,  v.va);
            chk1 ({tag, ".early_rsp"}, l1d.rsp_valid, 1'b0);
            clear_tlb = (v.clr == 2'd1);
            @(negedge clk);
            clear_tlb = (v.clr == 2'd2);
            chk1({tag, ".walk_pulse"}, walk_req, 1'b0);
            chk64({tag, ".walk_va_hold"}, walk_va, v.va);
            walk_rsp_valid      = 1'b1;
            walk_rsp            = '0;
            walk_rsp.paddr      = v.paddr;
            walk_rsp.pgsize     = v.pg;
            walk_rsp.fault      = v.wf;
            walk_rsp.readable   = v.r;
            walk_rsp.writable   = v.w;
            walk_rsp.dirty      = v.d;
            @(negedge clk);
            walk_rsp_valid = 1'b0;
            walk_rsp       = '0;
            clear_tlb      = 1'b0;
            chk1({tag, ".rsp_too_soon"}, l1d.rsp_valid, 1'b0);
            @(negedge clk);
        end else begin
            chk1({tag, ".no_walk"}, walk_req, 1'b0);
        end
        chk1({tag, ".rsp_valid"}, l1d.rsp_valid, 1'b1);
        chk1({tag, ".rsp_fault"}, l1d.rsp_fault, v.exp_fault);
        chk1({tag, ".rsp_hit"},   l1d.rsp_hit,   v.exp_hit);
        if (!v.exp_fault)
            chk64({tag, ".rsp_pa"}, l1d.rsp_pa, v.exp_pa);
        @(negedge clk);
        chk1({tag, ".rsp_pulse"}, l1d.rsp_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = mk(64'h40_1234, 1'b0, 1'b1, 2'd0, 64'h8020_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8020_0234, 1'b0, 1'b0);
        vecs[1]  = mk(64'h40_1234, 1'b0, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8020_0234, 1'b0, 1'b1);
        vecs[2]  = mk(64'h20_0000, 1'b0, 1'b1, 2'd0, 64'h8040_0000, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8040_0000, 1'b0, 1'b0);
        vecs[3]  = mk(64'h3F_F008, 1'b0, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h805F_F008, 1'b0, 1'b1);
        vecs[4]  = mk(64'h30_0000, 1'b1, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8050_0000, 1'b0, 1'b1);
        vecs[5]  = mk(64'h0080_0000_0000, 1'b0, 1'b0, 2'd0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        vecs[6]  = mk(64'hFFFF_FFC0_0000_1000, 1'b0, 1'b1, 2'd0, 64'h9000_0000, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 64'h9000_0000, 1'b0, 1'b0);
        vecs[7]  = mk(64'h40_1000, 1'b1, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 1'b1);
        vecs[8]  = mk(64'h60_0000, 1'b0, 1'b1, 2'd0, 64'hA000_0000, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 64'hA000_0000, 1'b0, 1'b0);
        vecs[9]  = mk(64'h60_0010, 1'b1, 1'b1, 2'd0, 64'hA000_0000, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 64'hA000_0010, 1'b0, 1'b0);
        vecs[10] = mk(64'h60_0020, 1'b1, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA000_0020, 1'b0, 1'b1);
        vecs[11] = mk(64'h70_0000, 1'b0, 1'b1, 2'd0, 64'h0,         2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 1'b0);
        vecs[12] = mk(64'h70_0000, 1'b0, 1'b1, 2'd0, 64'hB100_0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0,         1'b1, 1'b0);
        vecs[13] = mk(64'h70_0000, 1'b0, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 1'b1);
        vecs[14] = mk(64'h50_0000, 1'b0, 1'b1, 2'd1, 64'hB000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'hB000_0000, 1'b0, 1'b0);
        vecs[15] = mk(64'h50_0000, 1'b0, 1'b1, 2'd0, 64'hB000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'hB000_0000, 1'b0, 1'b0);
        vecs[16] = mk(64'h50_0000, 1'b0, 1'b0, 2'd0, 64'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hB000_0000, 1'b0, 1'b1);
        vecs[17] = mk(64'h51_0000, 1'b0, 1'b1, 2'd2, 64'hB200_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'hB200_0000, 1'b0, 1'b0);
        vecs[18] = mk(64'h51_0000, 1'b0, 1'b1, 2'd0, 64'hB200_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'hB200_0000, 1'b0, 1'b0);
        vecs[19] = mk(64'h40_1234, 1'b0, 1'b1, 2'd0, 64'h8020_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8020_0234, 1'b0, 1'b0);
        vecs[20] = mk(64'h4000_1234, 1'b0, 1'b1, 2'd0, 64'h1_4000_0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1_4000_1234, 1'b0, 1'b0);
        vecs[21] = mk(64'h7FFF_F000, 1'b0, 1'b0, 2'd0, 64'h0,       2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h1_7FFF_F000, 1'b0, 1'b1);

        reset          = 1'b1;
        clear_tlb      = 1'b0;
        walk_rsp_valid = 1'b0;
        walk_rsp       = '0;
        l1d.req_valid  = 1'b0;
        l1d.req_va     = '0;
        l1d.req_store  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_state("reset");

        for (int i = 0; i < 22; i++)
            do_req($sformatf("vec%0d", i), vecs[i]);

        // Walker responses outside WALK must not produce anything.
        @(negedge clk);
        walk_rsp_valid = 1'b1;
        walk_rsp.fault = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("spurious.rsp_valid", l1d.rsp_valid, 1'b0);
            chk1("spurious.ready", l1d.req_ready, 1'b1);
        end
        walk_rsp_valid = 1'b0;
        walk_rsp       = '0;
        do_req("spurious.after", vecs[21]);

        // Reset while the walk is outstanding abandons it silently.
        @(negedge clk);
        l1d.req_valid = 1'b1;
        l1d.req_va    = 64'h1234_5000;
        l1d.req_store = 1'b0;
        @(negedge clk);
        l1d.req_valid = 1'b0;
        @(negedge clk);
        chk1("rstwalk.walk_req", walk_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("rstwalk");
        walk_rsp_valid = 1'b1;
        walk_rsp.paddr = 64'hD000_0000;
        walk_rsp.readable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            walk_rsp_valid = 1'b0;
            chk1("rstwalk.no_rsp", l1d.rsp_valid, 1'b0);
        end
        walk_rsp = '0;

        // N+1 distinct 4K pages: the first one is evicted, the second survives.
        for (int i = 0; i <= N; i++) begin
            v = mk(64'h0100_0008 + (64'(i) << 12), 1'b0, 1'b1, 2'd0, 64'hC000_0000 + (64'(i) << 12), 2'd2,
                   1'b0, 1'b1, 1'b0, 1'b0, 64'hC000_0008 + (64'(i) << 12), 1'b0, 1'b0);
            do_req($sformatf("fill%0d", i), v);
        end
        v = mk(64'h0100_1008, 1'b0, 1'b0, 2'd0, 64'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hC000_1008, 1'b0, 1'b1);
        do_req("evict.page1_hit", v);
        v = mk(64'h0100_0008, 1'b0, 1'b1, 2'd0, 64'hC000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'hC000_0008, 1'b0, 1'b0);
        do_req("evict.page0_miss", v);
`ifdef TLB_STATS_EN
        chk64("stats.miss_count", 64'(miss_count), 64'(N + 2));
        chk64("stats.hit_count",  64'(hit_count),  64'd1);
`else
        chk64("stats.miss_count", 64'(miss_count), 64'd0);
        chk64("stats.hit_count",  64'(hit_count),  64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
